// File: rtl/wb_data_downsizer.sv
// Wishbone B3 data-width downsizer: splits each wide master access into one narrow
// slave beat per active lane group (big-endian, lowest group first), gathers read
// data and answers the master with a single ack/err/rty pulse.
//
// Ports
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o           wide (MW) classic slave port facing the interconnect
//   wbs_*_o / wbs_*_i           narrow (SW) classic master port facing the peripheral
//   wbm_cti_i, wbm_bte_i        ignored; every access is classic
module wb_data_downsizer #(
  parameter int unsigned AW = 32,
  parameter int unsigned MW = 32,
  parameter int unsigned SW = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   wbm_adr_i,
  input  logic [MW-1:0]   wbm_dat_i,
  input  logic [MW/8-1:0] wbm_sel_i,
  input  logic            wbm_we_i,
  input  logic            wbm_cyc_i,
  input  logic            wbm_stb_i,
  input  logic [2:0]      wbm_cti_i,
  input  logic [1:0]      wbm_bte_i,
  output logic [MW-1:0]   wbm_dat_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbm_rty_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [SW-1:0]   wbs_dat_o,
  output logic [SW/8-1:0] wbs_sel_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [SW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i
);

  localparam int unsigned R  = MW / SW;
  localparam int unsigned SB = SW / 8;
  localparam int unsigned MB = MW / 8;
  localparam int unsigned OB = $clog2(MB);
  localparam int unsigned GW = $clog2(R);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StResp} state_e;

  // Group 0 is the most significant lane.
  function automatic logic [SW-1:0] lane_dat(input logic [MW-1:0] d, input logic [GW-1:0] g);
    lane_dat = SW'(d >> ((int'(R) - 1 - int'(g)) * int'(SW)));
  endfunction

  function automatic logic [SB-1:0] lane_sel(input logic [MB-1:0] s, input logic [GW-1:0] g);
    lane_sel = SB'(s >> ((int'(R) - 1 - int'(g)) * int'(SB)));
  endfunction

  // Lowest active group >= lo; MSB flags that one was found.
  function automatic logic [GW:0] find_grp(input logic [MB-1:0] s, input int lo);
    find_grp = '0;
    for (int g = int'(R) - 1; g >= 0; g--) begin
      if (g >= lo && |lane_sel(s, GW'(g))) find_grp = {1'b1, GW'(g)};
    end
  endfunction

  function automatic logic [AW-1:0] grp_adr(input logic [AW-1:0] base, input logic [GW-1:0] g);
    grp_adr = base + AW'(int'(g) * int'(SB));
  endfunction

  state_e        state_q;
  logic [GW-1:0] grp_q;
  logic [AW-1:0] base_q;
  logic          we_q;
  logic [MB-1:0] sel_q;
  logic [MW-1:0] dat_q;
  logic [MW-1:0] rdat_q;
  logic [AW-1:0] s_adr_q;
  logic [SW-1:0] s_dat_q;
  logic [SB-1:0] s_sel_q;
  logic          s_we_q, s_cyc_q, s_stb_q;
  logic          m_ack_q, m_err_q, m_rty_q;

  logic [AW-1:0] base_in;
  logic [GW:0]   first_grp;
  logic [GW:0]   next_grp;
  logic          unused_in;

  assign base_in   = {wbm_adr_i[AW-1:OB], {OB{1'b0}}};
  assign first_grp = find_grp(wbm_sel_i, 0);
  assign next_grp  = find_grp(sel_q, int'(grp_q) + 1);
  assign unused_in = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[OB-1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      grp_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_sel_q <= '0;
      s_we_q  <= 1'b0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      m_rty_q <= 1'b0;
    end else begin
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      m_rty_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            base_q <= base_in;
            we_q   <= wbm_we_i;
            sel_q  <= wbm_sel_i;
            dat_q  <= wbm_dat_i;
            rdat_q <= '0;
            if (!first_grp[GW]) begin
              m_ack_q <= 1'b1;
              state_q <= StResp;
            end else begin
              grp_q   <= first_grp[GW-1:0];
              s_adr_q <= grp_adr(base_in, first_grp[GW-1:0]);
              s_dat_q <= lane_dat(wbm_dat_i, first_grp[GW-1:0]);
              s_sel_q <= lane_sel(wbm_sel_i, first_grp[GW-1:0]);
              s_we_q  <= wbm_we_i;
              s_cyc_q <= 1'b1;
              s_stb_q <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          // Master abort wins over any slave response in the same cycle.
          if (!wbm_cyc_i) begin
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            state_q <= StIdle;
          end else if (wbs_err_i || wbs_rty_i) begin
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            m_err_q <= wbs_err_i;
            m_rty_q <= !wbs_err_i;
            state_q <= StResp;
          end else if (wbs_ack_i) begin
            if (!we_q) begin
              for (int g = 0; g < int'(R); g++) begin
                if (grp_q == GW'(g)) rdat_q[int'(MW) - 1 - g * int'(SW) -: SW] <= wbs_dat_i;
              end
            end
            s_stb_q <= 1'b0;
            if (next_grp[GW]) begin
              // Next beat's address/data are set up during the gap.
              grp_q   <= next_grp[GW-1:0];
              s_adr_q <= grp_adr(base_q, next_grp[GW-1:0]);
              s_dat_q <= lane_dat(dat_q, next_grp[GW-1:0]);
              s_sel_q <= lane_sel(sel_q, next_grp[GW-1:0]);
              state_q <= StGap;
            end else begin
              s_cyc_q <= 1'b0;
              m_ack_q <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StGap: begin
          if (!wbm_cyc_i) begin
            s_cyc_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            s_stb_q <= 1'b1;
            state_q <= StReq;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = m_ack_q;
  assign wbm_err_o = m_err_q;
  assign wbm_rty_o = m_rty_q;
  assign wbs_adr_o = s_adr_q;
  assign wbs_dat_o = s_dat_q;
  assign wbs_sel_o = s_sel_q;
  assign wbs_we_o  = s_we_q;
  assign wbs_cyc_o = s_cyc_q;
  assign wbs_stb_o = s_stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

endmodule
